// File: rtl/decoder_pipe.sv
// decoder_pipe: binary-to-one-hot / thermometer decoder feeding a 2-entry
// in-order result FIFO with valid/ready handshakes on both sides, plus a
// saturating count of out-of-range codes.
//
// occupancy | meaning
// ----------+------------------------------------------------------
// EMPTY     | no result held; out_bits/out_err forced to zero
// ONE       | head entry valid, tail unused
// FULL      | head and tail valid; in_ready low until a pop

module decoder_pipe #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    input  logic             in_therm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_bits,
    output logic             out_err,
    output logic [7:0]       err_cnt
);

    generate
        if (IN_W < 1 || IN_W > 8) begin : g_bad_in_w
            $error("decoder_pipe: IN_W must be 1..8");
        end
        if (OUT_W < 2 || OUT_W > (2 ** IN_W)) begin : g_bad_out_w
            $error("decoder_pipe: OUT_W must be 2..2**IN_W");
        end
    endgenerate

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    logic [1:0]       occ;
    logic [OUT_W-1:0] head_bits;
    logic             head_err;
    logic [OUT_W-1:0] tail_bits;
    logic             tail_err;
    logic [OUT_W-1:0] dec_bits;
    logic             dec_err;
    logic             push;
    logic             pop;

    // Handshake flags depend only on occupancy so no input-to-output
    // combinational path exists through the ready/valid pair.
    assign in_ready  = (occ != OCC_FULL) && (occ != 2'd3);
    assign out_valid = (occ != OCC_EMPTY);
    assign out_bits  = head_bits;
    assign out_err   = head_err;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Decode the offered code; out-of-range codes decode to all-zero with error.
    always_comb begin
        int code_i;
        code_i   = int'({{(32 - IN_W){1'b0}}, in_code});
        dec_bits = '0;
        dec_err  = (code_i >= OUT_W);
        if (!dec_err) begin
            for (int i = 0; i < OUT_W; i++) begin
                dec_bits[i] = in_therm ? (i <= code_i) : (i == code_i);
            end
        end
    end

    // FIFO storage: head always drives the outputs, tail refills it on pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ       <= OCC_EMPTY;
            head_bits <= '0;
            head_err  <= 1'b0;
            tail_bits <= '0;
            tail_err  <= 1'b0;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (push) begin
                        head_bits <= dec_bits;
                        head_err  <= dec_err;
                        occ       <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head_bits <= dec_bits;
                        head_err  <= dec_err;
                    end else if (push) begin
                        tail_bits <= dec_bits;
                        tail_err  <= dec_err;
                        occ       <= OCC_FULL;
                    end else if (pop) begin
                        head_bits <= '0;
                        head_err  <= 1'b0;
                        occ       <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        head_bits <= tail_bits;
                        head_err  <= tail_err;
                        occ       <= OCC_ONE;
                    end
                end
                default: begin
                    head_bits <= '0;
                    head_err  <= 1'b0;
                    occ       <= OCC_EMPTY;
                end
            endcase
        end
    end

    // Count accepted out-of-range codes, holding at 255 rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else if (push && dec_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_decoder_pipe.sv
module tb_decoder_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // Default instance (IN_W=4, OUT_W=16)
    logic        in_valid = 1'b0, in_therm = 1'b0, out_ready = 1'b0;
    logic [3:0]  in_code = '0;
    logic        in_ready, out_valid, out_err;
    logic [15:0] out_bits;
    logic [7:0]  err_cnt;

    // Narrow-output instance (IN_W=4, OUT_W=10)
    logic        in_valid2 = 1'b0, in_therm2 = 1'b0, out_ready2 = 1'b0;
    logic [3:0]  in_code2 = '0;
    logic        in_ready2, out_valid2, out_err2;
    logic [9:0]  out_bits2;
    logic [7:0]  err_cnt2;

    int checks   = 0;
    int failures = 0;

    logic [16:0] q16[$];
    logic [10:0] q10[$];
    int          e10 = 0;

    always #5 clk = ~clk;

    decoder_pipe u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_therm(in_therm),
        .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits), .out_err(out_err),
        .err_cnt(err_cnt)
    );

    decoder_pipe #(.IN_W(4), .OUT_W(10)) u_dut10 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_code(in_code2), .in_therm(in_therm2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_bits(out_bits2), .out_err(out_err2),
        .err_cnt(err_cnt2)
    );

    // Reference decode: {err, bits} built arithmetically
    function automatic logic [16:0] exp16(input logic [3:0] c, input logic t);
        logic [31:0] v;
        v = t ? ((32'd2 << c) - 32'd1) : (32'd1 << c);
        return {1'b0, v[15:0]};
    endfunction

    function automatic logic [10:0] exp10(input logic [3:0] c, input logic t);
        logic [31:0] v;
        if (int'(c) >= 10) return {1'b1, 10'h0};
        v = t ? ((32'd2 << c) - 32'd1) : (32'd1 << c);
        return {1'b0, v[9:0]};
    endfunction

    task automatic cyc16(input logic v, input logic [3:0] c, input logic t, input logic r);
        logic exp_rdy, exp_ov, pu, po;
        logic [16:0] exp_head;
        @(negedge clk);
        in_valid = v; in_code = c; in_therm = t; out_ready = r;
        exp_rdy  = (q16.size() < 2);
        exp_ov   = (q16.size() > 0);
        exp_head = exp_ov ? q16[0] : 17'h0;
        checks++;
        if (in_ready !== exp_rdy) begin
            failures++; $display("FAIL in_ready: got %b want %b at %0t", in_ready, exp_rdy, $time);
        end
        checks++;
        if (out_valid !== exp_ov) begin
            failures++; $display("FAIL out_valid: got %b want %b at %0t", out_valid, exp_ov, $time);
        end
        checks++;
        if ({out_err, out_bits} !== exp_head) begin
            failures++; $display("FAIL head: got err=%b bits=%h want %h at %0t", out_err, out_bits, exp_head, $time);
        end
        pu = v && exp_rdy;
        po = r && exp_ov;
        if (po) void'(q16.pop_front());
        if (pu) q16.push_back(exp16(c, t));
        @(posedge clk);
    endtask

    task automatic cyc10(input logic v, input logic [3:0] c, input logic t, input logic r);
        logic exp_rdy, exp_ov, pu, po;
        logic [10:0] exp_head;
        @(negedge clk);
        in_valid2 = v; in_code2 = c; in_therm2 = t; out_ready2 = r;
        exp_rdy  = (q10.size() < 2);
        exp_ov   = (q10.size() > 0);
        exp_head = exp_ov ? q10[0] : 11'h0;
        checks++;
        if ({in_ready2, out_valid2} !== {exp_rdy, exp_ov}) begin
            failures++; $display("FAIL hs10: got rdy/ov=%b%b want %b%b at %0t", in_ready2, out_valid2, exp_rdy, exp_ov, $time);
        end
        checks++;
        if ({out_err2, out_bits2} !== exp_head) begin
            failures++; $display("FAIL head10: got err=%b bits=%h want %h at %0t", out_err2, out_bits2, exp_head, $time);
        end
        checks++;
        if (err_cnt2 !== 8'(e10)) begin
            failures++; $display("FAIL err_cnt10: got %0d want %0d at %0t", err_cnt2, e10, $time);
        end
        pu = v && exp_rdy;
        po = r && exp_ov;
        if (po) void'(q10.pop_front());
        if (pu) begin
            q10.push_back(exp10(c, t));
            if (int'(c) >= 10 && e10 < 255) e10++;
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({out_valid, out_bits, out_err, err_cnt, in_ready} !== {1'b0, 16'h0, 1'b0, 8'h0, 1'b1}) begin
            failures++; $display("FAIL reset16: ov=%b bits=%h err=%b cnt=%0d rdy=%b", out_valid, out_bits, out_err, err_cnt, in_ready);
        end
        checks++;
        if ({out_valid2, out_bits2, out_err2, err_cnt2} !== {1'b0, 10'h0, 1'b0, 8'h0}) begin
            failures++; $display("FAIL reset10: ov=%b bits=%h err=%b cnt=%0d", out_valid2, out_bits2, out_err2, err_cnt2);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        cyc16(0, 0, 0, 0);
    endtask

    task automatic test_onehot();
        for (int i = 0; i < 16; i++) cyc16(1, 4'(i), 0, 1);
        cyc16(0, 0, 0, 1);
        cyc16(0, 0, 0, 1);
    endtask

    task automatic test_therm();
        logic [3:0]  codes[3] = '{4'd3, 4'd15, 4'd0};
        logic [15:0] want[3]  = '{16'h000F, 16'hFFFF, 16'h0001};
        for (int i = 0; i < 3; i++) begin
            cyc16(1, codes[i], 1, 0);
            #1;
            checks++;
            if (out_bits !== want[i]) begin
                failures++; $display("FAIL therm code %0d: got %h want %h", codes[i], out_bits, want[i]);
            end
            cyc16(0, 0, 0, 1);
        end
        cyc16(0, 0, 0, 0);
    endtask

    task automatic test_range_err();
        cyc10(1, 4'd9, 0, 1);
        cyc10(1, 4'd9, 1, 1);
        cyc10(1, 4'd10, 0, 1);
        cyc10(1, 4'd12, 1, 1);
        cyc10(0, 0, 0, 1);
        cyc10(0, 0, 0, 1);
        // fresh count from here relative to the narrow instance model
        cyc10(1, 4'd12, 0, 0);
        #1;
        checks++;
        if ({out_err2, out_bits2, err_cnt2} !== {1'b1, 10'h0, 8'd3}) begin
            failures++; $display("FAIL oor12: got err=%b bits=%h cnt=%0d want err=1 bits=000 cnt=3", out_err2, out_bits2, err_cnt2);
        end
        cyc10(0, 0, 0, 1);
        for (int i = 0; i < 300; i++) cyc10(1, 4'd12, 0, 1);
        cyc10(0, 0, 0, 1);
        cyc10(0, 0, 0, 1);
        checks++;
        if (err_cnt2 !== 8'd255) begin
            failures++; $display("FAIL err_sat: got %0d want 255", err_cnt2);
        end
    endtask

    task automatic test_stall();
        cyc16(1, 4'd5, 0, 0);
        cyc16(1, 4'd6, 0, 0);
        #1;
        checks++;
        if ({in_ready, out_bits} !== {1'b0, 16'h0020}) begin
            failures++; $display("FAIL stall_full: got rdy=%b bits=%h want rdy=0 bits=0020", in_ready, out_bits);
        end
        cyc16(1, 4'd9, 0, 0);
        cyc16(1, 4'd9, 0, 0);
        cyc16(0, 0, 0, 1);
        #1;
        checks++;
        if ({in_ready, out_bits} !== {1'b1, 16'h0040}) begin
            failures++; $display("FAIL stall_pop1: got rdy=%b bits=%h want rdy=1 bits=0040", in_ready, out_bits);
        end
        cyc16(0, 0, 0, 1);
        cyc16(0, 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        cyc16(1, 4'd2, 0, 0);
        cyc16(1, 4'd7, 0, 1);
        #1;
        checks++;
        if ({out_valid, in_ready, out_bits} !== {1'b1, 1'b1, 16'h0080}) begin
            failures++; $display("FAIL b2b: got ov=%b rdy=%b bits=%h want 1 1 0080", out_valid, in_ready, out_bits);
        end
        cyc16(0, 0, 0, 1);
        cyc16(0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++)
            cyc16(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 3; i++) cyc16(0, 0, 0, 1);
    endtask

    task automatic test_rst_mid();
        cyc16(1, 4'd4, 0, 0);
        cyc16(1, 4'd8, 1, 0);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_bits, out_err, in_ready} !== {1'b0, 16'h0, 1'b0, 1'b1}) begin
            failures++; $display("FAIL rst_mid16: ov=%b bits=%h err=%b rdy=%b", out_valid, out_bits, out_err, in_ready);
        end
        checks++;
        if ({out_valid2, err_cnt2} !== {1'b0, 8'd0}) begin
            failures++; $display("FAIL rst_mid10: ov=%b cnt=%0d want 0 0", out_valid2, err_cnt2);
        end
        q16.delete(); q10.delete(); e10 = 0;
        @(negedge clk);
        in_valid = 1'b1; in_code = 4'd1; in_therm = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        cyc16(0, 0, 0, 0);
        cyc16(1, 4'd11, 0, 1);
        cyc16(0, 0, 0, 1);
        cyc16(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_onehot();
        test_therm();
        test_range_err();
        test_stall();
        test_back_to_back();
        test_random();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder_pipe.md
DECODER_PIPE -- requirements
Module: decoder_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 4, meaning code width in bits (1..8).
REQ-002 SHALL have parameter OUT_W, default 16, meaning decoded output width; legal range 2..2**IN_W, elaboration error otherwise.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning the reset, which is asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  meaning an input code is offered.
REQ-006 SHALL have port in_ready  output  1  meaning the block can accept a code this cycle.
REQ-007 SHALL have port in_code  input  IN_W  meaning the binary code to decode.
REQ-008 SHALL have port in_therm  input  1  meaning per-transaction mode: 0 selects one-hot, 1 selects thermometer.
REQ-009 SHALL have port out_valid  output  1  meaning out_bits and out_err hold a decoded result.
REQ-010 SHALL have port out_ready  input  1  meaning the consumer takes the result this cycle.
REQ-011 SHALL have port out_bits  output  OUT_W  meaning the decoded vector.
REQ-012 SHALL have port out_err  output  1  meaning the current result came from an out-of-range code.
REQ-013 SHALL have port err_cnt  output  8  meaning the count of accepted out-of-range codes.

Function
REQ-014 SHALL accept a transaction on a rising edge with in_valid=1 and in_ready=1 (push), and deliver one on a rising edge with out_valid=1 and out_ready=1 (pop).
REQ-015 SHALL buffer results in a 2-entry in-order FIFO; in_ready = (occupancy < 2), combinational from occupancy only, never from in_valid or out_ready.
REQ-016 SHALL drive out_valid = (occupancy > 0), with out_bits/out_err taken from the head entry and registered (no combinational path from in_* to out_*).
REQ-017 SHALL give one-cycle latency: a code pushed into an empty FIFO at edge N is presented with out_valid=1 from just after edge N.
REQ-018 SHALL, for one-hot mode with in_code < OUT_W, store exactly bit in_code set and all other bits clear.
REQ-019 SHALL, for thermometer mode with in_code < OUT_W, store bits [in_code:0] set and all bits above clear (code 0 gives bit 0 only).
REQ-020 SHALL, for in_code >= OUT_W in either mode, store out_bits all zero with out_err=1; otherwise store out_err=0.
REQ-021 SHALL hold out_bits/out_err stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on simultaneous push and pop at occupancy 1, keep occupancy 1 with the new entry at the head from the next cycle.
REQ-023 SHALL, at occupancy 2, ignore in_valid (no push); a pop at that edge drops occupancy to 1 and raises in_ready for the next cycle.
REQ-024 SHALL, at occupancy 0, ignore out_ready; occupancy never underflows or overflows.
REQ-025 SHALL increment err_cnt by 1 on each push with an out-of-range code, saturating at 255 (no wrap).
REQ-026 SHALL clear out_bits to zero whenever occupancy is 0.

Reset
REQ-027 SHALL, while rst=1, force occupancy 0, out_valid=0, out_bits=0, out_err=0 and err_cnt=0, independent of clk.
REQ-028 SHALL discard buffered entries when rst asserts mid-operation; pushes presented while rst=1 are dropped, though in_ready reads 1.
REQ-029 SHALL resume normal operation on the first rising edge after rst deasserts.

Verification
REQ-030 SHALL pass this check: defaults, one-hot, out_ready=1, in_code=0..15 back to back -> out_bits 16'h0001..16'h8000 one cycle later, no gaps, out_err=0.
REQ-031 SHALL pass this check: thermometer with in_code=3 -> 16'h000F; with in_code=15 -> 16'hFFFF; with in_code=0 -> 16'h0001.
REQ-032 SHALL pass this check: IN_W=4, OUT_W=10, in_code=12 -> out_bits=0, out_err=1, err_cnt=1; after 300 such codes err_cnt=255.
REQ-033 SHALL pass this check: out_ready=0, push codes 5 and 6 -> in_ready=0 after the second push, third offer stalls; out_ready=1 -> 16'h0020 then 16'h0040 in order, in_ready=1 after the first pop.
REQ-034 SHALL pass this check: occupancy 1, push code 7 with a simultaneous pop -> next head 16'h0080, occupancy 1.
REQ-035 SHALL pass this check: rst pulse between clock edges with 2 entries held -> out_valid=0, out_bits=0, err_cnt=0 immediately, with no stale entry after release.
